md5_msg_padder: RTL and testbench

- Responder side of the controller-to-hasher word interface.
- Accepts one candidate word (up to 16 bytes) plus its bit width from the brute-force controller and builds the single padded 512-bit MD5 block.
- Hands the block to the MD5 round core over a valid/ready handshake, waits for the digest, then returns it to the controller with a one-cycle output_valid pulse.
- Sits between the controller and the round core; owns all MD5 padding and length encoding.

---
 rtl/md5_msg_padder.sv | 172 +++++++++++++++++
 tb/tb_md5_msg_padder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/md5_msg_padder.sv
// MD5 single-block message padder between the brute-force controller and the round core.
// Optional length checking is enabled with MD5_PAD_LEN_CHECK_EN.
module md5_msg_padder #(
  parameter int MAX_BYTES = 16,
  parameter int DIGEST_W  = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [0:127]        word_in,
  input  logic [0:7]          word_in_width,
  input  logic                msg_in_valid,
  output logic                encrypter_ready,
  output logic [511:0]        blk,
  output logic                blk_valid,
  input  logic                blk_ready,
  input  logic [0:DIGEST_W-1] digest_in,
  input  logic                digest_valid,
  output logic [0:DIGEST_W-1] hashed_password,
  output logic                output_valid,
  output logic                len_err
);

  localparam int MAX_BITS = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [127:0]        msg_q, msg_d;
  logic [7:0]          width_q, width_d;
  logic [511:0]        blk_q, blk_d;
  logic                blk_valid_q, blk_valid_d;
  logic                ready_q, ready_d;
  logic [0:DIGEST_W-1] hash_q, hash_d;
  logic                output_valid_q, output_valid_d;

  // The message is right-aligned, so character i of an n-byte word sits at msg[8*(n-1-i) +: 8].
  function automatic logic [511:0] build_block(input logic [127:0] msg, input logic [7:0] bits);
    logic [511:0] b;
    int           n;
    b = '0;
    n = int'(bits) / 8;
    for (int i = 0; i < 16; i++) begin
      if (i < n) b[8*i +: 8] = msg[8*(n-1-i) +: 8];
    end
    b[8*n +: 8]   = 8'h80;
    b[448 +: 8]   = bits;
    return b;
  endfunction

`ifdef MD5_PAD_LEN_CHECK_EN
  function automatic logic len_bad(input logic [7:0] w);
    return (w[2:0] != 3'd0) || (int'(w) > MAX_BITS);
  endfunction

  logic len_err_q, len_err_d;
  assign len_err = len_err_q;
`else
  function automatic logic [7:0] eff_bits(input logic [7:0] w);
    int b;
    b = int'(w) & ~7;
    if (b > MAX_BITS) b = MAX_BITS;
    return 8'(b);
  endfunction

  assign len_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    width_d        = width_q;
    blk_d          = blk_q;
    blk_valid_d    = blk_valid_q;
    ready_d        = ready_q;
    hash_d         = hash_q;
    output_valid_d = 1'b0;
`ifdef MD5_PAD_LEN_CHECK_EN
    len_err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (msg_in_valid) begin
          msg_d   = word_in;
          width_d = word_in_width;
          ready_d = 1'b0;
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
`ifdef MD5_PAD_LEN_CHECK_EN
        if (len_bad(width_q)) begin
          len_err_d = 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          blk_d   = build_block(msg_q, width_q);
          state_d = ST_SEND;
        end
`else
        blk_d   = build_block(msg_q, eff_bits(width_q));
        state_d = ST_SEND;
`endif
      end
      // blk_valid rises one cycle after the block is built and holds until accepted.
      ST_SEND: begin
        if (!blk_valid_q) begin
          blk_valid_d = 1'b1;
        end else if (blk_ready) begin
          blk_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (digest_valid) begin
          hash_d         = digest_in;
          output_valid_d = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      msg_q          <= '0;
      width_q        <= '0;
      blk_q          <= '0;
      blk_valid_q    <= 1'b0;
      ready_q        <= 1'b1;
      hash_q         <= '0;
      output_valid_q <= 1'b0;
`ifdef MD5_PAD_LEN_CHECK_EN
      len_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      msg_q          <= msg_d;
      width_q        <= width_d;
      blk_q          <= blk_d;
      blk_valid_q    <= blk_valid_d;
      ready_q        <= ready_d;
      hash_q         <= hash_d;
      output_valid_q <= output_valid_d;
`ifdef MD5_PAD_LEN_CHECK_EN
      len_err_q      <= len_err_d;
`endif
    end
  end

  assign encrypter_ready = ready_q;
  assign blk             = blk_q;
  assign blk_valid       = blk_valid_q;
  assign hashed_password = hash_q;
  assign output_valid    = output_valid_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed self-checking bench for md5_msg_padder: padding, handshake, digest return, reset.
module tb_md5_msg_padder;

  logic         clock;
  logic         reset;
  logic [0:127] word_in;
  logic [0:7]   word_in_width;
  logic         msg_in_valid;
  logic         encrypter_ready;
  logic [511:0] blk;
  logic         blk_valid;
  logic         blk_ready;
  logic [0:127] digest_in;
  logic         digest_valid;
  logic [0:127] hashed_password;
  logic         output_valid;
  logic         len_err;

  int checks = 0;
  int errors = 0;

  md5_msg_padder dut (
    .clock          (clock),
    .reset          (reset),
    .word_in        (word_in),
    .word_in_width  (word_in_width),
    .msg_in_valid   (msg_in_valid),
    .encrypter_ready(encrypter_ready),
    .blk            (blk),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .digest_in      (digest_in),
    .digest_valid   (digest_valid),
    .hashed_password(hashed_password),
    .output_valid   (output_valid),
    .len_err        (len_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full zero-backpressure transaction: capture, pad, send, digest, response.
  task automatic run_block(input string tag, input logic [127:0] word, input logic [7:0] width,
                           input logic [511:0] exp_blk, input logic [127:0] dig);
    word_in       = word;
    word_in_width = width;
    msg_in_valid  = 1'b1;
    blk_ready     = 1'b1;
    step();
    msg_in_valid = 1'b0;
    check_output({tag, " ready_low"}, 512'(encrypter_ready), 512'd0);
    step();
    check_output({tag, " blk"}, blk, exp_blk);
    check_output({tag, " valid_not_yet"}, 512'(blk_valid), 512'd0);
    step();
    check_output({tag, " valid_rise"}, 512'(blk_valid), 512'd1);
    step();
    check_output({tag, " valid_drop"}, 512'(blk_valid), 512'd0);
    digest_in    = dig;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check_output({tag, " out_valid"}, 512'(output_valid), 512'd1);
    check_output({tag, " digest"}, 512'(hashed_password), 512'(dig));
    step();
    check_output({tag, " out_pulse_end"}, 512'(output_valid), 512'd0);
    check_output({tag, " ready_back"}, 512'(encrypter_ready), 512'd1);
    check_output({tag, " digest_hold"}, 512'(hashed_password), 512'(dig));
  endtask

  logic [511:0] exp_abc, exp_empty, exp_hi, exp_sat;

  initial begin
    reset         = 1'b1;
    word_in       = '0;
    word_in_width = '0;
    msg_in_valid  = 1'b0;
    blk_ready     = 1'b0;
    digest_in     = '0;
    digest_valid  = 1'b0;

    exp_abc = '0;
    exp_abc[31:0]    = 32'h80636261;
    exp_abc[455:448] = 8'h18;
    exp_empty = 512'h80;
    exp_hi = '0;
    exp_hi[23:0]     = 24'h804241;
    exp_hi[455:448]  = 8'h10;
    exp_sat = '0;
    exp_sat[127:0]   = 128'h0f0e0d0c0b0a09080706050403020100;
    exp_sat[135:128] = 8'h80;
    exp_sat[455:448] = 8'h80;

    step();
    step();
    reset = 1'b0;
    check_output("rst ready", 512'(encrypter_ready), 512'd1);
    check_output("rst blk", blk, 512'd0);
    check_output("rst blk_valid", 512'(blk_valid), 512'd0);
    check_output("rst hash", 512'(hashed_password), 512'd0);
    check_output("rst out_valid", 512'(output_valid), 512'd0);
    check_output("rst len_err", 512'(len_err), 512'd0);

    run_block("abc", 128'h616263, 8'd24, exp_abc, 128'h900150983cd24fb0d6963f7d28e17f72);
    run_block("empty", '1, 8'd0, exp_empty, 128'hd41d8cd98f00b204e9800998ecf8427e);

    // Backpressure with a foreign offer during SEND.
    word_in       = 128'h4142;
    word_in_width = 8'd16;
    msg_in_valid  = 1'b1;
    blk_ready     = 1'b0;
    step();
    msg_in_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("bp valid_held", 512'(blk_valid), 512'd1);
      check_output("bp blk_stable", blk, exp_hi);
      if (i == 2) begin
        word_in       = 128'h7a7a7a7a;
        word_in_width = 8'd32;
        msg_in_valid  = 1'b1;
      end else begin
        msg_in_valid = 1'b0;
      end
      step();
    end
    msg_in_valid = 1'b0;
    check_output("bp blk_after_offer", blk, exp_hi);
    blk_ready = 1'b1;
    step();
    check_output("bp accepted", 512'(blk_valid), 512'd0);
    check_output("bp ready_still_low", 512'(encrypter_ready), 512'd0);
    digest_in    = 128'h0123456789abcdef0011223344556677;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check_output("bp digest", 512'(hashed_password), 512'(128'h0123456789abcdef0011223344556677));
    check_output("bp out_valid", 512'(output_valid), 512'd1);
    step();
    check_output("bp ready_back", 512'(encrypter_ready), 512'd1);

`ifdef MD5_PAD_LEN_CHECK_EN
    word_in       = 128'h4142;
    word_in_width = 8'd20;
    msg_in_valid  = 1'b1;
    step();
    msg_in_valid = 1'b0;
    step();
    check_output("w20 len_err", 512'(len_err), 512'd1);
    check_output("w20 no_valid", 512'(blk_valid), 512'd0);
    check_output("w20 ready", 512'(encrypter_ready), 512'd1);
    step();
    check_output("w20 len_err_end", 512'(len_err), 512'd0);
    check_output("w20 still_no_valid", 512'(blk_valid), 512'd0);
    word_in       = 128'h000102030405060708090a0b0c0d0e0f;
    word_in_width = 8'd200;
    msg_in_valid  = 1'b1;
    step();
    msg_in_valid = 1'b0;
    step();
    check_output("w200 len_err", 512'(len_err), 512'd1);
    check_output("w200 no_valid", 512'(blk_valid), 512'd0);
    step();
`else
    run_block("w20", 128'h4142, 8'd20, exp_hi, 128'hcafef00d);
    run_block("w200", 128'h000102030405060708090a0b0c0d0e0f, 8'd200, exp_sat, 128'hbeef);
`endif

    // Reset while waiting for the digest, then a stale digest.
    word_in       = 128'h616263;
    word_in_width = 8'd24;
    msg_in_valid  = 1'b1;
    blk_ready     = 1'b1;
    step();
    msg_in_valid = 1'b0;
    step();
    step();
    step();
    check_output("mid in_wait", 512'(blk_valid), 512'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("mid ready", 512'(encrypter_ready), 512'd1);
    check_output("mid blk", blk, 512'd0);
    check_output("mid hash", 512'(hashed_password), 512'd0);
    check_output("mid out_valid", 512'(output_valid), 512'd0);
    digest_in    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    check_output("stale out_valid", 512'(output_valid), 512'd0);
    check_output("stale hash", 512'(hashed_password), 512'd0);
    step();
    check_output("stale out_valid2", 512'(output_valid), 512'd0);
    check_output("stale ready", 512'(encrypter_ready), 512'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
